// File: rtl/funnel_pkg.sv
// Shared constants and word types for the left funnel shifter.
package funnel_pkg;
  localparam int FS_WIDTH = 10;
  localparam int FS_AMT_W = 4;

  typedef logic [FS_WIDTH-1:0] fs_word_t;
  typedef logic [FS_AMT_W-1:0] fs_amt_t;
endpackage

// File: rtl/funnel_barrel_stage.sv
// One barrel level: shift left by a fixed power of two when enabled.
module funnel_barrel_stage #(
  parameter int W     = 20,
  parameter int SHIFT = 1
) (
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  assign q = en ? (d << SHIFT) : d;
endmodule

// File: rtl/left_funnel_shifter.sv
// Left funnel shifter: upper half of ({in1,in2} << amt), registered.
module left_funnel_shifter
  import funnel_pkg::*;
#(
  parameter int WIDTH = FS_WIDTH,
  parameter int AMT_W = FS_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
);
  logic [2*WIDTH-1:0] chain [AMT_W+1];

  assign chain[0] = {in1, in2};

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    funnel_barrel_stage #(
      .W     (2*WIDTH),
      .SHIFT (1 << k)
    ) u_stage (
      .en (amt[k]),
      .d  (chain[k]),
      .q  (chain[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        y <= chain[AMT_W][2*WIDTH-1 -: WIDTH];
    end
  end
endmodule

// File: tb/tb_left_funnel_shifter.sv
// Scoreboard bench for left_funnel_shifter.
module tb_left_funnel_shifter;
  import funnel_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     in_valid = 1'b0;
  fs_word_t in1 = '0;
  fs_word_t in2 = '0;
  fs_amt_t  amt = '0;
  logic     out_valid;
  fs_word_t y;

  fs_word_t q[$];
  fs_word_t last_y;
  fs_word_t e;
  int total = 0;
  int bad = 0;

  left_funnel_shifter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .amt       (amt),
    .out_valid (out_valid),
    .y         (y)
  );

  always #5 clk = ~clk;

  function automatic fs_word_t ref_y(fs_word_t a, fs_word_t b, fs_amt_t s);
    logic [2*FS_WIDTH-1:0] w;
    w = {a, b};
    w = w << s;
    return w[2*FS_WIDTH-1:FS_WIDTH];
  endfunction

  task automatic drive(logic v, fs_word_t a, fs_word_t b, fs_amt_t s);
    @(negedge clk);
    in_valid = v;
    in1 = a;
    in2 = b;
    amt = s;
    if (v) begin
      q.push_back(ref_y(a, b, s));
      last_y = ref_y(a, b, s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    total++;
    if (y !== 10'h000) begin
      bad++;
      $display("FAIL reset_y got=%h want=000", y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_y = '0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 10'h001, 10'h002, 4'd1);
      @(posedge clk);
      #1;
      total++;
      e = q.pop_front();
      if (out_valid !== 1'b1 || y !== e || e !== 10'h002) begin
        bad++;
        $display("FAIL b2b_%0d got=%b/%h want=1/002", i, out_valid, y);
      end
    end
  endtask

  task automatic test_funnel();
    fs_word_t a[3] = '{10'h001, 10'h201, 10'h201};
    fs_word_t b[3] = '{10'h001, 10'h201, 10'h201};
    fs_amt_t  s[3] = '{4'd1, 4'd2, 4'd1};
    fs_word_t w[3] = '{10'h002, 10'h006, 10'h003};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, a[i], b[i], s[i]);
      @(posedge clk);
      #1;
      total++;
      e = q.pop_front();
      if (out_valid !== 1'b1 || y !== w[i] || e !== w[i]) begin
        bad++;
        $display("FAIL funnel_%0d got=%b/%h want=1/%h", i, out_valid, y, w[i]);
      end
    end
  endtask

  task automatic test_boundary();
    fs_word_t b[3] = '{10'h155, 10'h155, 10'h3FF};
    fs_amt_t  s[3] = '{4'd0, 4'd10, 4'd15};
    fs_word_t w[3] = '{10'h2AA, 10'h155, 10'h3E0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10'h2AA, b[i], s[i]);
      @(posedge clk);
      #1;
      total++;
      e = q.pop_front();
      if (out_valid !== 1'b1 || y !== w[i] || e !== w[i]) begin
        bad++;
        $display("FAIL bound_amt%0d got=%b/%h want=1/%h", s[i], out_valid, y, w[i]);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 10'h3C3 ^ 10'(i), 10'h0F0 + 10'(i), fs_amt_t'(i + 3));
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || y !== last_y) begin
        bad++;
        $display("FAIL hold_%0d got=%b/%h want=0/%h", i, out_valid, y, last_y);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 10'h3FF, 10'h3FF, 4'd3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    last_y = '0;
    total++;
    if (out_valid !== 1'b0 || y !== 10'h000) begin
      bad++;
      $display("FAIL async_rst got=%b/%h want=0/000", out_valid, y);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || y !== 10'h000) begin
      bad++;
      $display("FAIL post_rst_idle got=%b/%h want=0/000", out_valid, y);
    end
    drive(1'b1, 10'h001, 10'h002, 4'd1);
    @(posedge clk);
    #1;
    total++;
    e = q.pop_front();
    if (out_valid !== 1'b1 || y !== 10'h002 || e !== 10'h002) begin
      bad++;
      $display("FAIL post_rst_first got=%b/%h want=1/002", out_valid, y);
    end
  endtask

  task automatic test_random();
    logic v;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 9) != 0);
      drive(v, fs_word_t'($urandom), fs_word_t'($urandom), fs_amt_t'(i % 16));
      @(posedge clk);
      #1;
      total++;
      if (v) begin
        e = q.pop_front();
        if (out_valid !== 1'b1 || y !== e) begin
          bad++;
          $display("FAIL rand_%0d amt=%0d got=%b/%h want=1/%h",
                   i, i % 16, out_valid, y, e);
        end
      end else if (out_valid !== 1'b0 || y !== last_y) begin
        bad++;
        $display("FAIL rand_hold_%0d got=%b/%h want=0/%h",
                 i, out_valid, y, last_y);
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_funnel();
    test_boundary();
    test_hold();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/left_funnel_shifter.md
Name: left_funnel_shifter

Overview:
- 10-bit left funnel shifter with one registered output stage.
- Concatenates two words as {in1, in2}, with in1 in the upper half, and shifts the 20-bit word left by amt.
- Returns the upper 10 bits: in1 shifted left, with the top amt bits of in2 funnelled in from the right.
- Used as a datapath primitive for rotates, double-word shifts and field extraction.

Parameters:
- WIDTH, 10, width of in1, in2 and y.
- AMT_W, 4, width of amt; legal shift range 0..2^AMT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in1/in2/amt this cycle.
- in1  input  WIDTH  upper (high) word of the funnel.
- in2  input  WIDTH  lower (low) word of the funnel.
- amt  input  AMT_W  left shift amount, unsigned.
- out_valid  output  1  y holds a new result.
- y  output  WIDTH  shifted result.

Behaviour:
- Function: y = upper WIDTH bits of ({in1,in2} << amt), computed as a 2*WIDTH-bit unsigned word with zero fill from the right.
- amt = 0: y = in1.
- 0 < amt < WIDTH: y = (in1 << amt) | (in2 >> (WIDTH-amt)).
- amt = WIDTH: y = in2.
- WIDTH < amt <= 2^AMT_W-1: y = in2 << (amt-WIDTH), zero-filled. For WIDTH=10, amt 11..15 are legal.
- Bits shifted out of the top are discarded; there is no overflow flag.
- Latency is exactly 1 clock: inputs sampled at rising edge N appear on y and out_valid after edge N.
- y loads only when in_valid=1; otherwise y holds its previous value.
- out_valid is registered from in_valid every cycle.
- No backpressure: a new operation may be issued every cycle, with throughput 1 per clock.
- Reset: while rst_n=0, y=0 and out_valid=0 immediately (asynchronous). Release is synchronous to clk; the first valid result appears 1 cycle after the first in_valid following release.
- Reset mid-operation discards the in-flight result; out_valid=0 until new input arrives.
- Combinational shift: log2 barrel structure of AMT_W stages (shift by 1, 2, 4, 8) on the 2*WIDTH-bit concatenation. No multiplier or divider.
- No X propagation: all outputs are defined from reset onward.

Decomposition:
- Shared package funnel_pkg:
  - constants FS_WIDTH=10 and FS_AMT_W=4;
  - typedef fs_word_t (logic [FS_WIDTH-1:0]);
  - typedef fs_amt_t (logic [FS_AMT_W-1:0]).
- One natural sub-module, funnel_barrel_stage:
  - parameterised by shift distance 2^k;
  - conditionally shifts the 2*WIDTH word left with zero fill when its amt bit is set.
- Top instantiates AMT_W stages, slices the upper WIDTH bits and registers them.

Test Plan:
- in1=0x001, in2=0x002, amt=1, in_valid=1 -> next cycle y=0x002, out_valid=1. Repeat the same vector back-to-back -> y stays 0x002 and out_valid stays 1.
- in1=0x001, in2=0x001, amt=1 -> y=0x002. Then in1=0x201, in2=0x201, amt=2 -> y=0x006. Then amt=1 -> y=0x003 (funnel bit from in2[9]).
- Boundaries with in1=0x2AA, in2=0x155:
  - amt=0 -> y=0x2AA;
  - amt=10 -> y=0x155;
  - with in2=0x3FF, amt=15 -> y=0x3E0.
- Hold: drive in_valid=0 while changing in1/in2/amt -> y holds its last value, out_valid=0.
- Reset: assert rst_n=0 mid-stream, asynchronously between clock edges -> y=0x000 and out_valid=0 immediately. After release, first vector (in1=0x001, in2=0x002, amt=1) -> y=0x002 one cycle later.
- Random sweep of 1000 vectors covering all amt 0..15 -> y matches the reference model, upper 10 bits of ({in1,in2}<<amt), with 1-cycle delay.
